internet_scheduler: RTL
=======================

// Module: internet_scheduler
// PURPOSE
//   Round-robin time-slot scheduler feeding internet_demux. Four requesters (Lib, FD, School,
//   Ribs) present 4-bit data plus a request. The block grants one requester at a time for a
//   bounded slot, then drives muxOutput/Enable/Sel straight into the demux inputs.
//   It holds the single shared link and guarantees fair, starvation-free access.
// PARAMETERS
//   SLOT_LEN  4  max cycles Enable stays high per grant (legal 1..15)
//   GAP_LEN   1  idle cycles with Enable low between consecutive grants (legal 0..15)
// PORTS
//   clk         in   1  single clock, rising edge
//   rst_n       in   1  synchronous, active-low reset
//   req         in   4  per-requester request; bit0 Lib, bit1 FD, bit2 School, bit3 Ribs
//   data_lib    in   4  Lib payload
//   data_fd     in   4  FD payload
//   data_school in   4  School payload
//   data_ribs   in   4  Ribs payload
//   muxOutput   out  4  registered payload of granted requester; 0 when Enable low
//   Enable      out  1  registered; high while a slot is active
//   Sel         out  2  registered index of the granted requester; holds its last value when idle
//   slot_done   out  1  one-cycle pulse on the cycle after the final Enable-high cycle of a slot
// BEHAVIOUR
//   Reset (rst_n low at an edge): state IDLE, muxOutput=0, Enable=0, Sel=0, slot_done=0,
//     rr pointer last=3, so Lib has top priority. Reset wins over every other event,
//     including mid-slot: Enable drops at that same edge.
//   States IDLE, GRANT, GAP; all outputs are registered.
//   IDLE: if req!=0, pick winner = first set bit searching last+1, last+2, ... mod 4.
//     At that edge: Sel<=winner, Enable<=1, muxOutput<=data[winner], last<=winner,
//     cnt<=1, then go to GRANT. If req==0, stay in IDLE.
//   Grant latency is 1 cycle: req is seen at edge t, and Enable/Sel are valid after edge t.
//   GRANT: at each edge, muxOutput<=data[Sel], so payload latency is 1 cycle and data
//     changes pass through. The slot ends at the edge where cnt==SLOT_LEN, or earlier
//     when req[Sel]==0 (early release).
//     At slot end: Enable<=0, muxOutput<=0, slot_done<=1.
//     Next state is GAP with gcnt<=1 if GAP_LEN>0.
//     If GAP_LEN==0, arbitrate in that same edge, as in IDLE, excluding nothing.
//     A back-to-back grant still lowers Enable for one cycle: slot_done marks the boundary.
//     Enable therefore stays high for exactly min(SLOT_LEN, cycles until req[Sel] is sampled low).
//   GAP: Enable=0, muxOutput=0. gcnt increments each edge. At gcnt==GAP_LEN, arbitrate as
//     in IDLE (grant if req!=0, else go to IDLE).
//   Fairness: a requester holding req high continuously is re-granted only after every
//     other active requester has had a slot.
//   Simultaneous requests: only the rr order decides; there is no fixed priority after reset.
//   A request that rises during another slot waits. No request is latched: it must be high
//     at the arbitration edge to win.
//   Counters are 4-bit saturating-free: cnt and gcnt never exceed their parameter values.
//   Sel never changes while Enable is high.
// STRUCTURE
//   Shared package internet_pkg:
//     IDX_LIB=0, IDX_FD=1, IDX_SCHOOL=2, IDX_RIBS=3
//     state localparams ST_IDLE / ST_GRANT / ST_GAP
//   Sub-module rr_pick: combinational 4-way round-robin picker.
//     Inputs req[3:0] and last[1:0]; outputs winner[1:0] and any.
//     Instantiate it once and share it between IDLE, GAP and GRANT(GAP_LEN==0) arbitration.
// TESTING
//   1. Reset, then req=4'b0001 with data_lib=4'hA held.
//      -> Enable high 4 cycles, Sel=0, muxOutput=A, then slot_done pulse, 1 gap cycle,
//         then regrant Lib.
//   2. req=4'b1111, constant data 1/2/3/4.
//      -> Sel sequence 0,1,2,3,0; each slot is 4 Enable cycles; muxOutput matches 1,2,3,4.
//   3. Lib granted, req[0] dropped after 2 Enable cycles.
//      -> Enable low on the next edge, slot_done=1, FD (req[1]=1) granted after the gap.
//   4. GAP_LEN=0, req=4'b0110.
//      -> Sel alternates 1,2, with a 1-cycle Enable-low gap marked by slot_done.
//   5. rst_n pulled low in cycle 2 of a School slot.
//      -> the next edge gives Enable=0, Sel=0, muxOutput=0; after release, req=4'b1100
//         grants School first (last=3).
//   6. Drive data_fd changing every cycle during an FD slot.
//      -> muxOutput equals data_fd delayed by 1 cycle. Cross-check with internet_demux:
//         FD gets the payload and Lib/School/Ribs stay 0.

Source files
------------

// File: rtl/internet_pkg.sv
// Shared constants and state encoding for the internet link scheduler and its picker.
package internet_pkg;

    localparam logic [1:0] IDX_LIB    = 2'd0;
    localparam logic [1:0] IDX_FD     = 2'd1;
    localparam logic [1:0] IDX_SCHOOL = 2'd2;
    localparam logic [1:0] IDX_RIBS   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/internet_scheduler_rr_pick.sv
// Combinational 4-way round-robin picker: first set request after 'last', wrapping mod 4.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] winner,
    output logic       any
);

    logic [1:0] idx;

    always_comb begin
        winner = last;
        any    = 1'b0;
        idx    = last;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last + k[1:0];
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/internet_scheduler.sv
// Round-robin time-slot scheduler: grants one requester at a time onto the shared demux link.
module internet_scheduler
    import internet_pkg::*;
#(
    parameter int unsigned SLOT_LEN = 4,
    parameter int unsigned GAP_LEN  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic [3:0] data_lib,
    input  logic [3:0] data_fd,
    input  logic [3:0] data_school,
    input  logic [3:0] data_ribs,
    output logic [3:0] muxOutput,
    output logic       Enable,
    output logic [1:0] Sel,
    output logic       slot_done
);

    localparam logic [3:0] SLOT_L = 4'(SLOT_LEN);
    localparam logic [3:0] GAP_L  = 4'(GAP_LEN);

    state_t     state_q;
    logic [3:0] mux_q;
    logic       en_q;
    logic [1:0] sel_q;
    logic       done_q;
    logic [1:0] last_q;
    logic [3:0] cnt_q;
    logic [3:0] gcnt_q;
    logic       pend_q;

    logic [3:0] data [4];
    logic [1:0] winner;
    logic       any;

    always_comb begin
        data[IDX_LIB]    = data_lib;
        data[IDX_FD]     = data_fd;
        data[IDX_SCHOOL] = data_school;
        data[IDX_RIBS]   = data_ribs;
    end

    rr_pick u_pick (
        .req    (req),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mux_q   <= '0;
            en_q    <= 1'b0;
            sel_q   <= '0;
            done_q  <= 1'b0;
            last_q  <= IDX_RIBS;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (any) begin
                        sel_q   <= winner;
                        last_q  <= winner;
                        en_q    <= 1'b1;
                        mux_q   <= data[winner];
                        cnt_q   <= 4'd1;
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (cnt_q == SLOT_L || !req[sel_q]) begin
                        en_q   <= 1'b0;
                        mux_q  <= '0;
                        done_q <= 1'b1;
                        if (GAP_LEN > 0) begin
                            gcnt_q  <= 4'd1;
                            state_q <= ST_GAP;
                        end else if (any) begin
                            // Zero-gap: the winner is chosen now, but Enable still
                            // rests low for one cycle via a pending pass through GAP.
                            sel_q   <= winner;
                            last_q  <= winner;
                            pend_q  <= 1'b1;
                            state_q <= ST_GAP;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                        mux_q <= data[sel_q];
                    end
                end
                ST_GAP: begin
                    if (pend_q) begin
                        pend_q  <= 1'b0;
                        en_q    <= 1'b1;
                        mux_q   <= data[sel_q];
                        cnt_q   <= 4'd1;
                        state_q <= ST_GRANT;
                    end else if (gcnt_q >= GAP_L) begin
                        if (any) begin
                            sel_q   <= winner;
                            last_q  <= winner;
                            en_q    <= 1'b1;
                            mux_q   <= data[winner];
                            cnt_q   <= 4'd1;
                            state_q <= ST_GRANT;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign muxOutput = mux_q;
    assign Enable    = en_q;
    assign Sel       = sel_q;
    assign slot_done = done_q;

endmodule
